// File: rtl/avmm_rr_arbiter_pkg.sv
// avmm_arb_pkg: shared types and constants for the Avalon-MM round-robin arbiter.
//   arb_state_e : controller states (IDLE, ISSUE, WAIT_RSP, DONE)
//   RSP_*       : 2-bit Avalon response codes returned to requesters
package avmm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } arb_state_e;

  localparam logic [1:0] RSP_OKAY   = 2'b00;
  localparam logic [1:0] RSP_SLVERR = 2'b10;
  localparam logic [1:0] RSP_DECERR = 2'b11;

endpackage

// File: rtl/avmm_rr_arbiter_if.sv
// Bus interfaces for the Avalon-MM round-robin arbiter.
//   avmm_req_if : NUM_REQ requester ports (address/read/write/writedata in,
//                 per-requester waitrequest, shared readdata/response out).
//                 master = requester side, slave = arbiter side.
//   avmm_m0_if  : single downstream Avalon-MM port.
//                 master = arbiter side, slave = downstream endpoint.
interface avmm_req_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_address;
  logic [NUM_REQ-1:0]             req_read;
  logic [NUM_REQ-1:0]             req_write;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_writedata;
  logic [NUM_REQ-1:0]             req_waitrequest;
  logic [DATA_W-1:0]              req_readdata;
  logic [1:0]                     req_response;

  modport master (
    output req_address, req_read, req_write, req_writedata,
    input  req_waitrequest, req_readdata, req_response
  );

  modport slave (
    input  req_address, req_read, req_write, req_writedata,
    output req_waitrequest, req_readdata, req_response
  );
endinterface

interface avmm_m0_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] avm_m0_address;
  logic [DATA_W-1:0] avm_m0_writedata;
  logic              avm_m0_read;
  logic              avm_m0_write;
  logic              avm_m0_waitrequest;
  logic [DATA_W-1:0] avm_m0_readdata;
  logic [1:0]        avm_m0_response;
  logic              avm_m0_readdatavalid;
  logic              avm_m0_writeresponsevalid;

  modport master (
    output avm_m0_address, avm_m0_writedata, avm_m0_read, avm_m0_write,
    input  avm_m0_waitrequest, avm_m0_readdata, avm_m0_response,
           avm_m0_readdatavalid, avm_m0_writeresponsevalid
  );

  modport slave (
    input  avm_m0_address, avm_m0_writedata, avm_m0_read, avm_m0_write,
    output avm_m0_waitrequest, avm_m0_readdata, avm_m0_response,
           avm_m0_readdatavalid, avm_m0_writeresponsevalid
  );
endinterface

// File: rtl/avmm_rr_arbiter_rr_arbiter.sv
// rr_arbiter: purely combinational round-robin picker.
//   i_eligible   : one bit per requester that wants service
//   i_last_grant : index of the most recently completed grant
//   o_grant      : one-hot winner, searching from i_last_grant+1 upward (wrapping)
//   o_valid      : at least one requester is eligible
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_eligible,
  input  logic [IDX_W-1:0]   i_last_grant,
  output logic [NUM_REQ-1:0] o_grant,
  output logic               o_valid
);

  logic [IDX_W-1:0] w_idx;
  logic             w_found;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = '0;
    // k runs 1..NUM_REQ so the previous winner is considered last
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = IDX_W'((int'(i_last_grant) + k) % NUM_REQ);
      if (!w_found && i_eligible[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
    o_valid = w_found;
  end

endmodule

// File: rtl/avmm_rr_arbiter.sv
// avmm_rr_arbiter: shares one downstream Avalon-MM port among NUM_REQ requesters
// with round-robin fairness, one transaction outstanding at a time.
//   clk   : clock, all logic on posedge
//   reset : synchronous, active-low
//   req   : avmm_req_if.slave  - requester commands in, per-requester
//           waitrequest and shared readdata/response out
//   m0    : avmm_m0_if.master  - downstream command out, completion in
// Optional feature macro AVMM_ARB_TIMEOUT_EN: a watchdog that completes a
// transaction with SLVERR after TIMEOUT cycles in ISSUE/WAIT_RSP.
// All outputs are registered.
module avmm_rr_arbiter
  import avmm_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  avmm_req_if.slave  req,
  avmm_m0_if.master  m0
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e          r_state;
  arb_state_e          w_state_nxt;

  logic [NUM_REQ-1:0]  w_eligible;
  logic [NUM_REQ-1:0]  w_pick_oh;
  logic                w_pick_vld;
  logic [IDX_W-1:0]    w_pick_idx;
  logic                w_pick_is_wr;

  logic [IDX_W-1:0]    r_last_grant;
  logic [IDX_W-1:0]    r_grant_idx;
  logic [NUM_REQ-1:0]  r_grant_oh;
  logic                r_is_write;

  logic                r_avm_read;
  logic                r_avm_write;
  logic [ADDR_W-1:0]   r_avm_addr;
  logic [DATA_W-1:0]   r_avm_wdata;

  logic [NUM_REQ-1:0]  r_waitreq;
  logic [DATA_W-1:0]   r_rdata;
  logic [1:0]          r_rsp;

  logic                w_accept;
  logic                w_rsp_vld;
  logic                w_timeout;

  assign w_eligible = req.req_read | req.req_write;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .i_eligible   (w_eligible),
    .i_last_grant (r_last_grant),
    .o_grant      (w_pick_oh),
    .o_valid      (w_pick_vld)
  );

  always_comb begin
    w_pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pick_oh[IDX_W'(i)]) w_pick_idx = IDX_W'(i);
    end
  end

  // Write wins when a requester raises both strobes
  assign w_pick_is_wr = |(w_pick_oh & req.req_write);

  assign w_accept  = (r_state == ISSUE) && !m0.avm_m0_waitrequest;
  // Completions are only honoured while waiting, and only of the matching kind
  assign w_rsp_vld = (r_state == WAIT_RSP) &&
                     (r_is_write ? m0.avm_m0_writeresponsevalid
                                 : m0.avm_m0_readdatavalid);

`ifdef AVMM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (r_state == IDLE && w_pick_vld) begin
      r_cnt <= '0;
    end else if (r_state == ISSUE || r_state == WAIT_RSP) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Fires in the cycle whose closing edge brings the count to TIMEOUT
  assign w_timeout = (r_state == ISSUE || r_state == WAIT_RSP) &&
                     (r_cnt == CNT_W'(TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:     if (w_pick_vld)     w_state_nxt = ISSUE;
      ISSUE:    if (w_timeout)      w_state_nxt = DONE;
                else if (w_accept)  w_state_nxt = WAIT_RSP;
      WAIT_RSP: if (w_rsp_vld || w_timeout) w_state_nxt = DONE;
      DONE:                         w_state_nxt = IDLE;
      default:                      w_state_nxt = IDLE;
    endcase
  end

  // Command capture, downstream strobes and completion outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_last_grant <= IDX_W'(NUM_REQ - 1);
      r_grant_idx  <= '0;
      r_grant_oh   <= '0;
      r_is_write   <= 1'b0;
      r_avm_read   <= 1'b0;
      r_avm_write  <= 1'b0;
      r_avm_addr   <= '0;
      r_avm_wdata  <= '0;
      r_waitreq    <= '1;
      r_rdata      <= '0;
      r_rsp        <= RSP_OKAY;
    end else begin
      // Waitrequest drops only for the single DONE cycle
      r_waitreq <= '1;
      case (r_state)
        IDLE: begin
          if (w_pick_vld) begin
            r_grant_oh  <= w_pick_oh;
            r_grant_idx <= w_pick_idx;
            r_is_write  <= w_pick_is_wr;
            r_avm_addr  <= req.req_address[w_pick_idx];
            r_avm_wdata <= req.req_writedata[w_pick_idx];
            r_avm_read  <= !w_pick_is_wr;
            r_avm_write <= w_pick_is_wr;
          end
        end
        ISSUE: begin
          if (w_timeout || w_accept) begin
            r_avm_read  <= 1'b0;
            r_avm_write <= 1'b0;
          end
          if (w_timeout) begin
            r_rdata   <= '0;
            r_rsp     <= RSP_SLVERR;
            r_waitreq <= ~r_grant_oh;
          end
        end
        WAIT_RSP: begin
          if (w_rsp_vld) begin
            r_rdata   <= r_is_write ? '0 : m0.avm_m0_readdata;
            r_rsp     <= m0.avm_m0_response;
            r_waitreq <= ~r_grant_oh;
          end else if (w_timeout) begin
            r_rdata   <= '0;
            r_rsp     <= RSP_SLVERR;
            r_waitreq <= ~r_grant_oh;
          end
        end
        DONE: begin
          r_last_grant <= r_grant_idx;
        end
        default: ;
      endcase
    end
  end

  assign m0.avm_m0_address   = r_avm_addr;
  assign m0.avm_m0_writedata = r_avm_wdata;
  assign m0.avm_m0_read      = r_avm_read;
  assign m0.avm_m0_write     = r_avm_write;

  assign req.req_waitrequest = r_waitreq;
  assign req.req_readdata    = r_rdata;
  assign req.req_response    = r_rsp;

endmodule

// File: tb/tb_avmm_rr_arbiter.sv
// Self-checking bench for avmm_rr_arbiter: directed requester stimulus, a
// behavioural downstream slave, and a completion monitor fed by a scoreboard.
// Define AVMM_ARB_TIMEOUT_EN to exercise the watchdog with TIMEOUT=8.
module tb_avmm_rr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;
  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 32;
`ifdef AVMM_ARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic [1:0]  rsp;
    int          cyc;
  } cpl_t;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  cpl_t exp_cpl[$];
  cmd_t exp_cmd[$];
  int   rem[NUM_REQ];

  // Downstream model knobs
  int          ds_stall  = 0;
  int          ds_delay  = 1;
  bit          ds_silent = 1'b0;
  logic [31:0] ds_rdata  = 32'h0;
  logic [1:0]  ds_rsp    = 2'b00;

  avmm_req_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) rif ();
  avmm_m0_if  #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mif ();

  avmm_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .req   (rif),
    .m0    (mif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic push_cpl(int idx, logic [31:0] rdata, logic [1:0] rsp, int c);
    cpl_t e;
    e.idx = idx; e.rdata = rdata; e.rsp = rsp; e.cyc = c;
    exp_cpl.push_back(e);
  endtask

  task automatic push_cmd(logic wr, logic [15:0] addr, logic [31:0] wdata);
    cmd_t e;
    e.wr = wr; e.addr = addr; e.wdata = wdata;
    exp_cmd.push_back(e);
  endtask

  task automatic issue(int i, logic rd, logic wr, logic [15:0] addr,
                       logic [31:0] wdata, int n);
    rif.req_address[IDX_W'(i)]   = addr;
    rif.req_writedata[IDX_W'(i)] = wdata;
    rif.req_read[IDX_W'(i)]      = rd;
    rif.req_write[IDX_W'(i)]     = wr;
    rem[i] = n;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (exp_cpl.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) begin
      total++;
      bad++;
      $display("FAIL wait_idle timed out, %0d completions outstanding", exp_cpl.size());
      exp_cpl.delete();
    end
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_waitreq"}, 64'(rif.req_waitrequest), 64'(4'hF));
    chk({tag, "_rdata"},   64'(rif.req_readdata), 64'h0);
    chk({tag, "_rsp"},     64'(rif.req_response), 64'h0);
    chk({tag, "_strobes"}, 64'({mif.avm_m0_read, mif.avm_m0_write}), 64'h0);
    chk({tag, "_addr"},    64'(mif.avm_m0_address), 64'h0);
    chk({tag, "_wdata"},   64'(mif.avm_m0_writedata), 64'h0);
  endtask

  // Completion monitor: pops the scoreboard whenever a waitrequest drops,
  // and plays the requester side by withdrawing finished commands.
  initial begin
    logic [NUM_REQ-1:0] w;
    int   idx;
    cpl_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && rif.req_waitrequest !== {NUM_REQ{1'b1}}) begin
        w   = ~rif.req_waitrequest;
        idx = 0;
        for (int i = 0; i < NUM_REQ; i++) if (w[IDX_W'(i)]) idx = i;
        chk("cpl_onehot", 64'($countones(w)), 64'd1);
        if (exp_cpl.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_cpl requester=%0d required=none (cycle %0d)", idx, cyc);
        end else begin
          e = exp_cpl.pop_front();
          chk("cpl_idx",   64'(idx), 64'(e.idx));
          chk("cpl_rdata", 64'(rif.req_readdata), 64'(e.rdata));
          chk("cpl_rsp",   64'(rif.req_response), 64'(e.rsp));
          if (e.cyc >= 0) chk("cpl_cycle", 64'(cyc), 64'(e.cyc));
          chk("cpl_bus_idle", 64'({mif.avm_m0_read, mif.avm_m0_write}), 64'h0);
        end
        for (int i = 0; i < NUM_REQ; i++) begin
          if (w[IDX_W'(i)]) begin
            if (rem[i] > 1) begin
              rem[i]--;
              rif.req_address[IDX_W'(i)]   = rif.req_address[IDX_W'(i)] + 16'd4;
              rif.req_writedata[IDX_W'(i)] = rif.req_writedata[IDX_W'(i)] + 32'h10;
            end else begin
              rem[i] = 0;
              rif.req_read[IDX_W'(i)]  = 1'b0;
              rif.req_write[IDX_W'(i)] = 1'b0;
            end
          end
        end
      end
    end
  end

  // Downstream slave model
  initial begin
    bit   in_cmd;
    int   stall_left;
    int   cnt;
    bit   pend_wr;
    cmd_t h;
    in_cmd = 0; stall_left = 0; cnt = 0; pend_wr = 0;
    mif.avm_m0_waitrequest        = 1'b1;
    mif.avm_m0_readdatavalid      = 1'b0;
    mif.avm_m0_writeresponsevalid = 1'b0;
    mif.avm_m0_readdata           = 32'h0;
    mif.avm_m0_response           = 2'b00;
    forever begin
      @(negedge clk);
      mif.avm_m0_waitrequest        = 1'b1;
      mif.avm_m0_readdatavalid      = 1'b0;
      mif.avm_m0_writeresponsevalid = 1'b0;
      mif.avm_m0_readdata           = 32'hBAD0BAD0;
      mif.avm_m0_response           = 2'b01;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          if (pend_wr) mif.avm_m0_writeresponsevalid = 1'b1;
          else begin
            mif.avm_m0_readdatavalid = 1'b1;
            mif.avm_m0_readdata      = ds_rdata;
          end
          mif.avm_m0_response = ds_rsp;
        end
      end
      if (mif.avm_m0_read === 1'b1 || mif.avm_m0_write === 1'b1) begin
        if (!in_cmd) begin
          in_cmd     = 1;
          stall_left = ds_stall;
        end
        if (exp_cmd.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_cmd addr=%0h required=none (cycle %0d)", mif.avm_m0_address, cyc);
        end else begin
          h = exp_cmd[0];
          chk("cmd_kind", 64'({mif.avm_m0_read, mif.avm_m0_write}), 64'({~h.wr, h.wr}));
          chk("cmd_addr", 64'(mif.avm_m0_address), 64'(h.addr));
          if (h.wr) chk("cmd_wdata", 64'(mif.avm_m0_writedata), 64'(h.wdata));
        end
        if (stall_left > 0) begin
          stall_left--;
        end else begin
          mif.avm_m0_waitrequest = 1'b0;
          if (exp_cmd.size() != 0) void'(exp_cmd.pop_front());
          in_cmd  = 0;
          pend_wr = mif.avm_m0_write;
          cnt     = ds_silent ? 0 : ds_delay;
        end
      end else begin
        // Command withdrawn while stalled (watchdog or reset)
        if (in_cmd && exp_cmd.size() != 0) void'(exp_cmd.pop_front());
        in_cmd = 0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "bench stopped by watchdog");
  end

  initial begin
    int c;
    reset = 1'b0;
    rif.req_address   = '0;
    rif.req_writedata = '0;
    rif.req_read      = '0;
    rif.req_write     = '0;
    for (int i = 0; i < NUM_REQ; i++) rem[i] = 0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst_init");
    reset = 1'b1;
    @(negedge clk);

    // All four write continuously; requester 0 twice -> grants 0,1,2,3,0
    for (int i = 0; i < NUM_REQ; i++)
      issue(i, 1'b0, 1'b1, 16'(16'h1000 + i * 16'h100), 32'(32'hA0000000 + i), (i == 0) ? 2 : 1);
    for (int i = 0; i < NUM_REQ; i++)
      push_cmd(1'b1, 16'(16'h1000 + i * 16'h100), 32'(32'hA0000000 + i));
    push_cmd(1'b1, 16'h1004, 32'hA0000010);
    for (int i = 0; i < NUM_REQ; i++) push_cpl(i, 32'h0, 2'b00, -1);
    push_cpl(0, 32'h0, 2'b00, -1);
    wait_idle();

    // Single read from requester 1, best-case latency
    ds_rdata = 32'hDEADBEEF; ds_rsp = 2'b00;
    c = cyc;
    issue(1, 1'b1, 1'b0, 16'h0010, 32'h0, 1);
    push_cmd(1'b0, 16'h0010, 32'h0);
    push_cpl(1, 32'hDEADBEEF, 2'b00, c + 3);
    wait_idle();

    // Stalled write from requester 3, SLVERR write response
    ds_stall = 5; ds_rsp = 2'b10;
    c = cyc;
    issue(3, 1'b0, 1'b1, 16'h0300, 32'h12345678, 1);
    push_cmd(1'b1, 16'h0300, 32'h12345678);
    push_cpl(3, 32'h0, 2'b10, c + 8);
    wait_idle();
    ds_stall = 0; ds_rsp = 2'b00;

    // Requester 2 raises read and write together -> write only
    c = cyc;
    issue(2, 1'b1, 1'b1, 16'h0200, 32'h55AA55AA, 1);
    push_cmd(1'b1, 16'h0200, 32'h55AA55AA);
    push_cpl(2, 32'h0, 2'b00, c + 3);
    wait_idle();

    // Read with DECERR passed through
    ds_rdata = 32'h0BADF00D; ds_rsp = 2'b11;
    c = cyc;
    issue(0, 1'b1, 1'b0, 16'h0040, 32'h0, 1);
    push_cmd(1'b0, 16'h0040, 32'h0);
    push_cpl(0, 32'h0BADF00D, 2'b11, c + 3);
    wait_idle();
    ds_rsp = 2'b00;

    // Reset during WAIT_RSP, late readdatavalid must be ignored
    ds_delay = 5; ds_rdata = 32'hCAFEF00D;
    issue(2, 1'b1, 1'b0, 16'h0220, 32'h0, 1);
    push_cmd(1'b0, 16'h0220, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rif.req_read  = '0;
    rif.req_write = '0;
    for (int i = 0; i < NUM_REQ; i++) rem[i] = 0;
    @(negedge clk);
    chk_reset_vals("rst_mid");
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk_reset_vals("rst_late");
    ds_delay = 1; ds_rdata = 32'h11112222;
    issue(0, 1'b1, 1'b0, 16'h0400, 32'h0, 1);
    issue(3, 1'b1, 1'b0, 16'h0430, 32'h0, 1);
    push_cmd(1'b0, 16'h0400, 32'h0);
    push_cmd(1'b0, 16'h0430, 32'h0);
    push_cpl(0, 32'h11112222, 2'b00, -1);
    push_cpl(3, 32'h11112222, 2'b00, -1);
    wait_idle();

`ifdef AVMM_ARB_TIMEOUT_EN
    // Downstream never accepts: watchdog fires in ISSUE
    ds_stall = 1000;
    c = cyc;
    issue(1, 1'b1, 1'b0, 16'h0510, 32'h0, 1);
    push_cmd(1'b0, 16'h0510, 32'h0);
    push_cpl(1, 32'h0, 2'b10, c + 1 + TO);
    wait_idle();
    ds_stall = 0;

    // Downstream accepts but never responds: watchdog fires in WAIT_RSP
    ds_silent = 1'b1;
    c = cyc;
    issue(2, 1'b0, 1'b1, 16'h0520, 32'h77778888, 1);
    push_cmd(1'b1, 16'h0520, 32'h77778888);
    push_cpl(2, 32'h0, 2'b10, c + 1 + TO);
    wait_idle();
    ds_silent = 1'b0;
`endif

    repeat (3) @(negedge clk);
    chk("cmd_queue_empty", 64'(exp_cmd.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/avmm_rr_arbiter.md
# avmm_rr_arbiter

Round-robin arbiter that shares one downstream Avalon-MM slave port (a NoC endpoint, register block or default slave) among NUM_REQ requesters. It accepts one transaction at a time, drives it downstream, waits for the read-data or write-response, and returns data and a 2-bit response to the granted requester. An optional watchdog completes hung transactions with SLVERR.

## Interface
- NUM_REQ, 4: number of requesters, 2..8
- ADDR_W, 16: address width
- DATA_W, 32: data width
- TIMEOUT, 255: response watchdog limit in cycles, 1..65535
- clk  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-low (reset == 0 resets the block)
- req_address  in  NUM_REQ x ADDR_W  per-requester address
- req_read / req_write  in  NUM_REQ  per-requester command; held until own waitrequest is low
- req_writedata  in  NUM_REQ x DATA_W  per-requester write data
- req_waitrequest  out  NUM_REQ  high except during the single completion cycle
- req_readdata  out  DATA_W  shared; valid for the requester whose waitrequest is low
- req_response  out  2  shared; 00 OKAY, 10 SLVERR, 11 DECERR
- avm_m0_address / avm_m0_writedata  out  ADDR_W / DATA_W  downstream command
- avm_m0_read / avm_m0_write  out  1  downstream strobes
- avm_m0_waitrequest  in  1  downstream stall
- avm_m0_readdata  in  DATA_W; avm_m0_response  in  2
- avm_m0_readdatavalid / avm_m0_writeresponsevalid  in  1  downstream completion

## Operation
- FSM states: IDLE, ISSUE, WAIT_RSP, DONE.
- IDLE: eligible = req_read | req_write. Search starts at last_grant+1 mod NUM_REQ; the first eligible index wins. Register grant, command, address and data; go to ISSUE. No eligible requester: stay in IDLE.
- A requester asserting both read and write is treated as a write.
- ISSUE: drive the registered command. Hold while avm_m0_waitrequest = 1. On acceptance, go to WAIT_RSP.
- WAIT_RSP, write: wait for writeresponsevalid. Read: wait for readdatavalid. Then capture readdata (writes capture 0) and response, and go to DONE.
- DONE: req_waitrequest[grant] = 0 for exactly one cycle. Update last_grant := grant. Go to IDLE.
- Downstream valids outside WAIT_RSP are ignored.
- A requester dropping its command after grant is a protocol violation. The transaction still completes and the DONE pulse is still issued.
- Reset mid-operation: return to IDLE immediately. The downstream command deasserts. The in-flight result is discarded.
- Reset values: req_waitrequest all 1; req_readdata 0; req_response 00; avm_m0_read/write 0; avm_m0_address/writedata 0; last_grant NUM_REQ-1, so requester 0 wins first.

## Timing
- Best-case latency: request seen in IDLE at cycle 0, downstream accepts in cycle 1, response valid in cycle 2, waitrequest low in cycle 3.
- Each transaction occupies at least 4 cycles, one outstanding at a time.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Starvation bound: a continuously requesting requester is served within NUM_REQ transactions.

## Configuration
- AVMM_ARB_TIMEOUT_EN defined:
  - a counter clears on entry to ISSUE and increments each cycle in ISSUE or WAIT_RSP;
  - when the count reaches TIMEOUT, go to DONE with response 10 and readdata 0, and deassert the downstream strobes;
  - counter width is $clog2(TIMEOUT+1).
- Undefined: no counter; the block waits indefinitely.

## Structure
- Package avmm_arb_pkg holds: the state enum; response constants RSP_OKAY 2'b00, RSP_SLVERR 2'b10, RSP_DECERR 2'b11.
- Sub-module rr_arbiter:
  - combinational picker from the eligible vector and last_grant;
  - outputs a one-hot grant plus a valid flag;
  - the top level registers the result.

## Test plan
- Single requester 1, read 0x0010, downstream returns 0xDEADBEEF/00 one cycle after accept -> req_waitrequest[1] low in cycle 3 with readdata 0xDEADBEEF, response 00.
- All 4 requesting writes continuously -> grants in order 0,1,2,3,0; each gets exactly one completion cycle.
- Downstream waitrequest held 5 cycles, then write response 10 -> command stable throughout; requester sees response 10 and readdata 0.
- With AVMM_ARB_TIMEOUT_EN and TIMEOUT=8, downstream never responds -> completion 8 cycles after entering ISSUE, response 10, strobes deasserted.
- reset driven low while in WAIT_RSP, then a late readdatavalid -> all outputs at reset values, valid ignored, next grant goes to requester 0.
- Requester 2 asserts read and write together -> downstream sees a write only.
